fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC core. It holds the PC, addresses instruction memory, and selects the next PC from the decode stage's 2-bit `Psel` redirect code. It latches the fetched word, PC and PC+1 into the IF/ID register, whose `ifid_inst[31:27]` drives the control unit's opcode input. It also applies stall and squash rules and keeps two wrapping performance counters.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, 32'h0000_0000: instruction word inserted as a bubble.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  from the hazard unit; holds PC and IF/ID.
- `Psel`  in  2  from decode for the instruction now in ID: 00 PC+1, 01 branch target, 10 jump/call target, 11 register target (JR/return).
- `branch_target`  in  32  used when `Psel`=01.
- `jump_target`  in  32  used when `Psel`=10.
- `reg_target`  in  32  used when `Psel`=11.
- `imem_addr`  out  32  instruction memory address; equals `pc`.
- `imem_data`  in  32  instruction word; combinational read of `imem_addr`.
- `ifid_inst`  out  32  IF/ID instruction; bits [31:27] are the opcode.
- `ifid_pc`  out  32  PC of `ifid_inst`.
- `ifid_pc_plus1`  out  32  `ifid_pc`+1; used as the CALL return address.
- `ifid_valid`  out  1  0 when the IF/ID register holds a bubble.
- `redirect`  out  1  combinational; high when `Psel`≠00 and `stall`=0.
- `fetch_cnt`  out  CNT_W  count of valid instructions loaded into IF/ID.
- `squash_cnt`  out  CNT_W  count of bubbles inserted by redirects.

## Operation
- PC is word-addressed; sequential next PC is `pc`+1, mod 2^32. At 32'hFFFF_FFFF it wraps to 0 with no flag.
- Next PC when `stall`=0 is selected by `Psel`: 00 gives `pc`+1, 01 `branch_target`, 10 `jump_target`, 11 `reg_target`.
- Normal load (`stall`=0, `Psel`=00):
  - `ifid_inst` ← `imem_data`
  - `ifid_pc` ← `pc`
  - `ifid_pc_plus1` ← `pc`+1
  - `ifid_valid` ← 1
  - `fetch_cnt` increments
- Redirect (`stall`=0, `Psel`≠00): the word now in IF is wrong-path.
  - `ifid_inst` ← `NOP_INST`, `ifid_valid` ← 0
  - `ifid_pc` ← `pc`, `ifid_pc_plus1` ← `pc`+1
  - `pc` ← target
  - `squash_cnt` increments
- Stall (`stall`=1): `pc`, all IF/ID fields and both counters hold. `Psel` is ignored.
  - Stall has priority over redirect. Decode keeps `Psel` and the targets stable until `stall` drops, and the redirect takes effect on the first unstalled edge.
- Two-state FSM on the validity of the IF/ID register:
  - BOOT (entered on reset; IF/ID holds a bubble).
  - RUN (IF/ID holds a valid instruction).
  - BOOT→RUN on the first unstalled edge with `Psel`=00.
  - RUN→BOOT on any unstalled redirect. Otherwise the state holds.
  - `ifid_valid` is 1 exactly when the state is RUN.
- Counters wrap modulo 2^CNT_W and are never saturated.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `pc`=`RESET_PC`
  - `ifid_inst`=`NOP_INST`, `ifid_valid`=0
  - `ifid_pc`=0, `ifid_pc_plus1`=0
  - both counters 0, state BOOT
- Reset takes effect immediately, including mid-stall or mid-redirect. The first fetch after release is from `RESET_PC`.
- `imem_addr` follows `pc` with no delay. An instruction appears in IF/ID one edge after its address is presented.
- Redirect penalty is exactly one bubble: the target address is presented the cycle after the redirect edge, and the target instruction reaches IF/ID on the following edge.
- `redirect` and `imem_addr` are combinational. All other outputs are registered.

## Test plan
- Reset, then 4 unstalled cycles with `Psel`=00 and `imem_data` = 0xA0+addr:
  - `ifid_pc` sequence is 0,1,2,3.
  - `ifid_inst` sequence is A0,A1,A2,A3.
  - `fetch_cnt`=4, `squash_cnt`=0.
- At `pc`=5, `Psel`=01 with `branch_target`=0x40:
  - next edge: `ifid_valid`=0, `ifid_inst`=NOP, `squash_cnt`=1, `imem_addr`=0x40.
  - following edge: `ifid_pc`=0x40.
- `stall`=1 for 3 cycles at `pc`=8 with `Psel`=10 and `jump_target`=0x100 held:
  - `pc` and IF/ID unchanged; counters frozen.
  - first edge after release: `pc`=0x100, one bubble.
- `Psel`=11 with `reg_target`=0x2C, then `Psel`=00:
  - IF/ID sequence is bubble, then `ifid_pc`=0x2C with `ifid_pc_plus1`=0x2D.
- Preset `pc`=32'hFFFF_FFFF, unstalled sequential fetch:
  - next `pc`=0.
  - `ifid_pc_plus1`=0 for the instruction fetched at 32'hFFFF_FFFF.
- Assert `rst_n`=0 mid-cycle while `stall`=1 and `Psel`=01:
  - outputs reach reset values immediately, without waiting for an edge.
  - after release, `imem_addr`=`RESET_PC` and the first valid IF/ID instruction is the one at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC
// core. It holds the word-addressed PC and presents it to instruction memory.
// Each unstalled edge it loads the fetched word into IF/ID and selects the next
// PC from the decode stage's redirect code. A redirect discards the word
// currently in IF by loading a bubble instead. Two wrapping counters record
// valid fetches and squashed slots.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hazard-unit hold: PC, IF/ID and counters keep their values
//   Psel           next-PC select from decode:
//                    00 pc+1, 01 branch, 10 jump/call, 11 register (JR/return)
//   branch_target  next PC when Psel = 01
//   jump_target    next PC when Psel = 10
//   reg_target     next PC when Psel = 11
//   imem_addr      instruction memory address (combinational, equals pc)
//   imem_data      instruction word read combinationally at imem_addr
//   ifid_inst      IF/ID instruction; bits [31:27] feed the control unit opcode
//   ifid_pc        PC of ifid_inst
//   ifid_pc_plus1  ifid_pc + 1, used as the CALL return address
//   ifid_valid     0 while IF/ID holds a bubble
//   redirect       combinational: Psel != 00 and not stalled
//   fetch_cnt      number of valid instructions loaded into IF/ID
//   squash_cnt     number of bubbles inserted by redirects
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       Psel,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      reg_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      ifid_inst,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_pc_plus1,
    output logic             ifid_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    // BOOT: IF/ID holds a bubble. RUN: IF/ID holds a valid instruction.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] pc_nxt;

    // Sequential successor wraps silently from 32'hFFFF_FFFF to 0.
    assign pc_plus1  = pc + 32'd1;
    assign imem_addr = pc;

    // Stall outranks redirect; decode holds Psel and the targets until the
    // stall drops, so the redirect simply takes effect on that later edge.
    assign redirect  = (Psel != 2'b00) && !stall;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_nxt = pc_plus1;
        unique case (Psel)
            2'b01:   pc_nxt = branch_target;
            2'b10:   pc_nxt = jump_target;
            2'b11:   pc_nxt = reg_target;
            default: pc_nxt = pc_plus1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (!stall) begin
            state_nxt = redirect ? BOOT : RUN;
        end
    end

    assign ifid_valid = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state         <= BOOT;
            pc            <= RESET_PC;
            ifid_inst     <= NOP_INST;
            ifid_pc       <= 32'd0;
            ifid_pc_plus1 <= 32'd0;
            fetch_cnt     <= '0;
            squash_cnt    <= '0;
        end else if (!stall) begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc_plus1;
            if (redirect) begin
                // The word now in IF is wrong-path: replace it with a bubble.
                ifid_inst  <= NOP_INST;
                squash_cnt <= squash_cnt + 1'b1;
            end else begin
                ifid_inst  <= imem_data;
                fetch_cnt  <= fetch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Instruction memory returns 0xA0 + address.
// Each step drives stall/Psel, pushes the expected post-edge IF/ID and counter
// state onto a scoreboard queue, then pops and compares it after the edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int          CNT_W    = 16;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic [1:0]       Psel;
    logic [31:0]      branch_target;
    logic [31:0]      jump_target;
    logic [31:0]      reg_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      ifid_inst;
    logic [31:0]      ifid_pc;
    logic [31:0]      ifid_pc_plus1;
    logic             ifid_valid;
    logic             redirect;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] squash_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc1;
        logic        valid;
        logic [15:0] fc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .Psel          (Psel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_inst     (ifid_inst),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .redirect      (redirect),
        .fetch_cnt     (fetch_cnt),
        .squash_cnt    (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    always_comb imem_data = 32'hA0 + imem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        check({e.tag, ".imem_addr"},     imem_addr,             e.addr);
        check({e.tag, ".ifid_inst"},     ifid_inst,             e.inst);
        check({e.tag, ".ifid_pc"},       ifid_pc,               e.pc);
        check({e.tag, ".ifid_pc_plus1"}, ifid_pc_plus1,         e.pc1);
        check({e.tag, ".ifid_valid"},    {31'd0, ifid_valid},   {31'd0, e.valid});
        check({e.tag, ".fetch_cnt"},     {16'd0, fetch_cnt},    {16'd0, e.fc});
        check({e.tag, ".squash_cnt"},    {16'd0, squash_cnt},   {16'd0, e.sc});
    endtask

    task automatic check_reset_values(input string tag);
        exp_t e;
        e = '{tag: tag, addr: RESET_PC, inst: NOP_INST, pc: 32'd0, pc1: 32'd0,
              valid: 1'b0, fc: 16'd0, sc: 16'd0};
        compare(e);
    endtask

    // One clock step: drive inputs, check redirect, push expectation,
    // clock, then pop the oldest expectation and compare.
    task automatic step(input string tag, input logic s, input logic [1:0] p,
                        input logic exp_redir,
                        input logic [31:0] e_addr, input logic [31:0] e_inst,
                        input logic [31:0] e_pc, input logic [31:0] e_pc1,
                        input logic e_valid, input logic [15:0] e_fc,
                        input logic [15:0] e_sc);
        exp_t e;
        stall = s;
        Psel  = p;
        #1;
        check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, exp_redir});
        e = '{tag: tag, addr: e_addr, inst: e_inst, pc: e_pc, pc1: e_pc1,
              valid: e_valid, fc: e_fc, sc: e_sc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed 0 entries expected 1", tag);
        end else begin
            compare(sb.pop_front());
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        Psel          = 2'b00;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        reg_target    = 32'h0;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC.
        step("seq0", 1'b0, 2'b00, 1'b0, 32'd1, 32'hA0, 32'd0, 32'd1, 1'b1, 16'd1, 16'd0);
        step("seq1", 1'b0, 2'b00, 1'b0, 32'd2, 32'hA1, 32'd1, 32'd2, 1'b1, 16'd2, 16'd0);
        step("seq2", 1'b0, 2'b00, 1'b0, 32'd3, 32'hA2, 32'd2, 32'd3, 1'b1, 16'd3, 16'd0);
        step("seq3", 1'b0, 2'b00, 1'b0, 32'd4, 32'hA3, 32'd3, 32'd4, 1'b1, 16'd4, 16'd0);
        step("seq4", 1'b0, 2'b00, 1'b0, 32'd5, 32'hA4, 32'd4, 32'd5, 1'b1, 16'd5, 16'd0);

        // Branch at pc=5 to 0x40: one bubble, then target instruction.
        branch_target = 32'h40;
        step("br",    1'b0, 2'b01, 1'b1, 32'h40, NOP_INST, 32'd5,  32'd6,  1'b0, 16'd5, 16'd1);
        step("br_t",  1'b0, 2'b00, 1'b0, 32'h41, 32'hE0,   32'h40, 32'h41, 1'b1, 16'd6, 16'd1);

        // Jump to 7, fetch it, leaving pc=8 with a valid IF/ID.
        jump_target = 32'h7;
        step("jmp7",  1'b0, 2'b10, 1'b1, 32'h7, NOP_INST, 32'h41, 32'h42, 1'b0, 16'd6, 16'd2);
        step("at7",   1'b0, 2'b00, 1'b0, 32'h8, 32'hA7,   32'h7,  32'h8,  1'b1, 16'd7, 16'd2);

        // Stall for 3 cycles with a pending jump to 0x100: everything holds.
        jump_target = 32'h100;
        step("stall0", 1'b1, 2'b10, 1'b0, 32'h8, 32'hA7, 32'h7, 32'h8, 1'b1, 16'd7, 16'd2);
        step("stall1", 1'b1, 2'b10, 1'b0, 32'h8, 32'hA7, 32'h7, 32'h8, 1'b1, 16'd7, 16'd2);
        step("stall2", 1'b1, 2'b10, 1'b0, 32'h8, 32'hA7, 32'h7, 32'h8, 1'b1, 16'd7, 16'd2);
        step("jmp_rel", 1'b0, 2'b10, 1'b1, 32'h100, NOP_INST, 32'h8, 32'h9, 1'b0, 16'd7, 16'd3);
        step("jmp_t",  1'b0, 2'b00, 1'b0, 32'h101, 32'h1A0, 32'h100, 32'h101, 1'b1, 16'd8, 16'd3);

        // Register-target redirect to 0x2C.
        reg_target = 32'h2C;
        step("jr",    1'b0, 2'b11, 1'b1, 32'h2C, NOP_INST, 32'h101, 32'h102, 1'b0, 16'd8, 16'd4);
        step("jr_t",  1'b0, 2'b00, 1'b0, 32'h2D, 32'hCC,   32'h2C,  32'h2D,  1'b1, 16'd9, 16'd4);

        // PC wrap: jump to 32'hFFFF_FFFF, then sequential fetch.
        reg_target = 32'hFFFF_FFFF;
        step("to_max", 1'b0, 2'b11, 1'b1, 32'hFFFF_FFFF, NOP_INST, 32'h2D, 32'h2E, 1'b0, 16'd9, 16'd5);
        step("wrap",   1'b0, 2'b00, 1'b0, 32'h0, 32'h9F, 32'hFFFF_FFFF, 32'h0, 1'b1, 16'd10, 16'd5);
        step("after_wrap", 1'b0, 2'b00, 1'b0, 32'h1, 32'hA0, 32'h0, 32'h1, 1'b1, 16'd11, 16'd5);

        // Asynchronous reset mid-cycle during a stalled branch.
        stall         = 1'b1;
        Psel          = 2'b01;
        branch_target = 32'h55;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        stall = 1'b0;
        Psel  = 2'b00;
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.imem_addr", imem_addr, RESET_PC);
        step("post_rst", 1'b0, 2'b00, 1'b0, 32'd1, 32'hA0, 32'd0, 32'd1, 1'b1, 16'd1, 16'd0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
